// File: rtl/demux1to8_buf_if.sv
// rtl/demux1to8_buf_if.sv - upstream word and eight-channel output bundle for demux1to8_buf
interface demux1to8_buf_if #(
   parameter int WIDTH = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [2:0]         sel;
   logic [WIDTH-1:0]   din;
   logic               bcast;
   logic [7:0]         dout_valid;
   logic [7:0]         dout_ready;
   logic [8*WIDTH-1:0] dout;
   logic               busy;

   modport master (
      output in_valid, sel, din, bcast, dout_ready,
      input  in_ready, dout_valid, dout, busy
   );

   modport slave (
      input  in_valid, sel, din, bcast, dout_ready,
      output in_ready, dout_valid, dout, busy
   );
endinterface

// File: rtl/demux1to8_buf.sv
// rtl/demux1to8_buf.sv - 1-to-8 demux with a one-entry register per output channel
// Optional broadcast to all channels is enabled by defining DEMUX_BCAST_EN.
module demux1to8_buf #(
   parameter int WIDTH = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   demux1to8_buf_if.slave  bus
);
   logic [7:0]       vld_q;
   logic [WIDTH-1:0] data_q [8];
   logic [7:0]       vld_out;
   logic [7:0]       free;
   logic [7:0]       ld;
   logic             bc_mode;
   logic             rdy;
   logic             xfer;

`ifdef DEMUX_BCAST_EN
   assign bc_mode = bus.bcast;
`else
   logic unused_bcast;
   assign unused_bcast = bus.bcast;
   assign bc_mode      = 1'b0;
`endif

   // A channel can take a word if it is empty or being drained on this edge.
   assign free = ~vld_q | bus.dout_ready;

   // Ready never looks at din or in_valid, so upstream may present X data while idle.
   always_comb begin
      rdy = free[bus.sel];
      if (bc_mode) begin
         rdy = &free;
      end
   end

   assign bus.in_ready = rst_n & rdy;
   assign xfer         = bus.in_valid & bus.in_ready;

   always_comb begin
      ld = '0;
      for (int k = 0; k < 8; k++) begin
         ld[k] = xfer & (bc_mode | (bus.sel == 3'(k)));
      end
   end

   genvar g;
   generate
      for (g = 0; g < 8; g++) begin : g_chan
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               vld_q[g]  <= 1'b0;
               data_q[g] <= '0;
            end else if (ld[g]) begin
               vld_q[g]  <= 1'b1;
               data_q[g] <= bus.din;
            end else if (bus.dout_ready[g]) begin
               vld_q[g]  <= 1'b0;
            end
         end

         assign bus.dout[g*WIDTH +: WIDTH] = data_q[g];
      end
   endgenerate

   // Valid is masked during reset so consumers never see a drain on a reset edge.
   assign vld_out        = vld_q & {8{rst_n}};
   assign bus.dout_valid = vld_out;
   assign bus.busy       = |vld_out;
endmodule

// File: tb/tb_demux1to8_buf.sv
// tb/tb_demux1to8_buf.sv - table-driven bench for demux1to8_buf
module tb_demux1to8_buf;
   typedef struct {
      logic        rst;
      logic        vld;
      logic [2:0]  sel;
      logic        bc;
      logic [31:0] din;
      logic [7:0]  rdy;
      logic        e_ir;
      logic [7:0]  e_dv;
      logic [2:0]  chk;
      logic [31:0] e_d;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   vec_t tv [18];
   logic [31:0] exp_ch [8];

   demux1to8_buf_if #(.WIDTH(32)) bus ();

   demux1to8_buf #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic v, input logic [2:0] s, input logic b,
                        input logic [31:0] d, input logic [7:0] rd);
      rst_n          = r;
      bus.in_valid   = v;
      bus.sel        = s;
      bus.bcast      = b;
      bus.din        = d;
      bus.dout_ready = rd;
   endtask

   initial begin
      drive(1'b0, 1'b0, 3'd0, 1'b0, 32'h0, 8'h00);

      //          rst   vld   sel   bc    din            rdy    ir    dv     chk   data
      tv[0]  = '{1'b0, 1'b0, 3'd0, 1'b0, 32'h0,        8'hFF, 1'b0, 8'h00, 3'd0, 32'h0};
      tv[1]  = '{1'b1, 1'b1, 3'd3, 1'b0, 32'hDEADBEEF, 8'hFF, 1'b1, 8'h08, 3'd3, 32'hDEADBEEF};
      tv[2]  = '{1'b1, 1'b0, 3'd0, 1'b0, 32'h0,        8'hFF, 1'b1, 8'h00, 3'd3, 32'hDEADBEEF};
      tv[3]  = '{1'b1, 1'b1, 3'd5, 1'b0, 32'h11,       8'h00, 1'b1, 8'h20, 3'd5, 32'h11};
      tv[4]  = '{1'b1, 1'b1, 3'd5, 1'b0, 32'h22,       8'h00, 1'b0, 8'h20, 3'd5, 32'h11};
      tv[5]  = '{1'b1, 1'b1, 3'd5, 1'b0, 32'h22,       8'h20, 1'b1, 8'h20, 3'd5, 32'h22};
      tv[6]  = '{1'b1, 1'b0, 3'd0, 1'b0, 32'h0,        8'h20, 1'b1, 8'h00, 3'd5, 32'h22};
      tv[7]  = '{1'b1, 1'b1, 3'd2, 1'b0, 32'h77,       8'h00, 1'b1, 8'h04, 3'd2, 32'h77};
      tv[8]  = '{1'b1, 1'b1, 3'd6, 1'b0, 32'h33,       8'h00, 1'b1, 8'h44, 3'd6, 32'h33};
      tv[9]  = '{1'b1, 1'b0, 3'd2, 1'b0, 32'h0,        8'h00, 1'b0, 8'h44, 3'd2, 32'h77};
      tv[10] = '{1'b1, 1'b1, 3'd1, 1'b0, 32'h99,       8'h00, 1'b1, 8'h46, 3'd1, 32'h99};
      tv[11] = '{1'b1, 1'b1, 3'd1, 1'b0, 32'h44,       8'h02, 1'b1, 8'h46, 3'd1, 32'h44};
      tv[12] = '{1'b1, 1'b1, 3'd0, 1'b0, 32'hAA,       8'h00, 1'b1, 8'h47, 3'd0, 32'hAA};
      tv[13] = '{1'b1, 1'b1, 3'd7, 1'b0, 32'hBB,       8'h00, 1'b1, 8'hC7, 3'd7, 32'hBB};
      tv[14] = '{1'b0, 1'b1, 3'd4, 1'b0, 32'hCC,       8'hFF, 1'b0, 8'h00, 3'd7, 32'h0};
      tv[15] = '{1'b1, 1'b1, 3'd4, 1'b0, 32'h12,       8'h00, 1'b1, 8'h10, 3'd4, 32'h12};
`ifdef DEMUX_BCAST_EN
      tv[16] = '{1'b1, 1'b1, 3'd0, 1'b1, 32'h55,       8'h00, 1'b0, 8'h10, 3'd4, 32'h12};
      tv[17] = '{1'b1, 1'b1, 3'd0, 1'b1, 32'h55,       8'h10, 1'b1, 8'hFF, 3'd4, 32'h55};
      for (int k = 0; k < 8; k++) exp_ch[k] = 32'h55;
`else
      tv[16] = '{1'b1, 1'b1, 3'd0, 1'b1, 32'h55,       8'h00, 1'b1, 8'h11, 3'd0, 32'h55};
      tv[17] = '{1'b1, 1'b1, 3'd0, 1'b1, 32'h55,       8'h10, 1'b0, 8'h01, 3'd0, 32'h55};
      for (int k = 0; k < 8; k++) exp_ch[k] = 32'h0;
      exp_ch[0] = 32'h55;
      exp_ch[4] = 32'h12;
`endif

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(tv[i].rst, tv[i].vld, tv[i].sel, tv[i].bc, tv[i].din, tv[i].rdy);
         #1;
         chk($sformatf("v%0d in_ready", i), {31'b0, bus.in_ready}, {31'b0, tv[i].e_ir});
         if (!tv[i].rst) chk($sformatf("v%0d busy_in_rst", i), {31'b0, bus.busy}, 32'h0);
         @(posedge clk);
         #1;
         chk($sformatf("v%0d dout_valid", i), {24'b0, bus.dout_valid}, {24'b0, tv[i].e_dv});
         chk($sformatf("v%0d busy", i), {31'b0, bus.busy}, {31'b0, |tv[i].e_dv});
         chk($sformatf("v%0d ch%0d data", i, tv[i].chk), bus.dout[tv[i].chk*32 +: 32], tv[i].e_d);
         if (!tv[i].rst) chk($sformatf("v%0d dout_zero", i), {31'b0, bus.dout == '0}, 32'h1);
      end

      for (int k = 0; k < 8; k++) begin
         chk($sformatf("final ch%0d", k), bus.dout[k*32 +: 32], exp_ch[k]);
      end

      @(negedge clk);
      drive(1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
      @(posedge clk);
      #1;
      chk("drain_all dout_valid", {24'b0, bus.dout_valid}, 32'h0);

      // Back-to-back stream across channels with consumers always ready.
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         drive(1'b1, 1'b1, 3'(i % 8), 1'b0, 32'h1000 + 32'(i), 8'hFF);
         #1;
         chk($sformatf("s%0d in_ready", i), {31'b0, bus.in_ready}, 32'h1);
         @(posedge clk);
         #1;
         chk($sformatf("s%0d dout_valid", i), {24'b0, bus.dout_valid}, {24'b0, 8'h01 << (i % 8)});
         chk($sformatf("s%0d data", i), bus.dout[(i % 8)*32 +: 32], 32'h1000 + 32'(i));
      end

      @(negedge clk);
      drive(1'b1, 1'b0, 3'd0, 1'b0, 32'h0, 8'hFF);
      @(posedge clk);
      #1;
      chk("idle dout_valid", {24'b0, bus.dout_valid}, 32'h0);
      chk("idle busy", {31'b0, bus.busy}, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/demux1to8_buf.md
DEMUX1TO8_BUF -- requirements
Module: demux1to8_buf

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the data width of the input and of each output channel.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: the reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: the block accepts the upstream word this cycle.
REQ-006 The block SHALL have port sel, input, 3 bits: destination channel index 0..7, meaningful only when in_valid=1.
REQ-007 The block SHALL have port din, input, WIDTH bits: the upstream data word.
REQ-008 The block SHALL have port bcast, input, 1 bit: the broadcast request (see Configuration).
REQ-009 The block SHALL have port dout_valid, output, 8 bits: bit k means channel k holds a word.
REQ-010 The block SHALL have port dout_ready, input, 8 bits: bit k means the channel-k consumer takes the word this cycle.
REQ-011 The block SHALL have port dout, output, 8*WIDTH bits: channel k data on bits [k*WIDTH +: WIDTH].
REQ-012 The block SHALL have port busy, output, 1 bit: equal to the OR of all dout_valid bits.

Function
REQ-013 Each channel k SHALL be a one-entry register with two states:
- EMPTY (dout_valid[k]=0)
- FULL (dout_valid[k]=1)
REQ-014 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; a drain of channel k SHALL occur on a rising edge where dout_valid[k]=1 and dout_ready[k]=1.
REQ-015 For a unicast request (bcast=0 or broadcast compiled out), in_ready SHALL equal (!dout_valid[sel] | dout_ready[sel]).
REQ-016 The in_ready value SHALL depend only on sel, bcast, dout_valid and dout_ready, and never on din.
REQ-017 On a unicast transfer, channel sel SHALL load din and become FULL at that edge; the word SHALL be visible on dout one cycle after acceptance, with no combinational path from din to dout.
REQ-018 Channel transitions SHALL be:
- EMPTY->FULL on a transfer to the channel;
- FULL->EMPTY on a drain without a transfer to the channel;
- FULL stays FULL with new data on a simultaneous drain and transfer (full throughput, one word per cycle per channel).
REQ-019 A FULL channel that is not drained SHALL hold its data and valid bit stable.
REQ-020 Transfers to different channels on consecutive cycles SHALL be independent: a stalled channel SHALL NOT block words addressed to other channels.
REQ-021 Per-channel word order SHALL equal acceptance order; words SHALL never be dropped or duplicated.
REQ-022 When in_valid=0, the sel, din and bcast inputs SHALL be ignored, including when they are X.
REQ-023 Channels not addressed by a transfer SHALL NOT change their data registers.

Reset
REQ-024 While rst_n=0 at a rising edge, all dout_valid bits SHALL clear to 0 and all dout data registers SHALL clear to 0.
REQ-025 While rst_n=0, in_ready SHALL be driven 0 and busy SHALL be 0.
REQ-026 Reset asserted mid-operation SHALL discard all held words, and no drain SHALL be reported on that edge.
REQ-027 The first transfer SHALL be possible on the first edge with rst_n=1.

Configuration
REQ-028 The macro DEMUX_BCAST_EN SHALL control the broadcast feature, and the bcast port SHALL exist in both builds.
REQ-029 With DEMUX_BCAST_EN defined and bcast=1:
- in_ready SHALL equal the AND over k of (!dout_valid[k] | dout_ready[k]);
- on a transfer, all 8 channels SHALL load din and become FULL;
- sel SHALL be ignored.
REQ-030 With DEMUX_BCAST_EN undefined, bcast SHALL be ignored and every request SHALL behave as unicast.

Verification
REQ-031 The bench SHALL cover, after reset, all dout_ready=1, in_valid=1, sel=3, din=0xDEADBEEF for one cycle -> dout_valid=8'h08 for exactly one cycle, and dout[127:96]=0xDEADBEEF.
REQ-032 The bench SHALL cover dout_ready=0, sel=5, din=0x11 then din=0x22 -> the first word is accepted, then in_ready=0 with channel 5 holding 0x11; after dout_ready[5]=1, 0x22 is accepted and channel 5 delivers 0x11 then 0x22.
REQ-033 The bench SHALL cover channel 2 FULL and stalled, then a transfer to sel=6 with din=0x33 -> in_ready=1, channel 6 FULL with 0x33, and channel 2 unchanged.
REQ-034 The bench SHALL cover channel 1 FULL with dout_ready[1]=1 and a simultaneous transfer with sel=1, din=0x44 -> channel 1 stays FULL with 0x44 and no bubble occurs.
REQ-035 The bench SHALL cover rst_n=0 for one cycle while channels 0 and 7 are FULL -> dout_valid=0, all dout=0, busy=0, and in_ready=0 during that cycle.
REQ-036 The bench SHALL cover, with DEMUX_BCAST_EN defined, bcast=1, din=0x55 and channel 4 FULL and stalled -> in_ready=0; after releasing dout_ready[4], dout_valid=8'hFF with every channel holding 0x55; without the macro, the same stimulus with sel=0 -> only channel 0 loads.
